// File: rtl/rom_msg_uart_tx_pkg.sv
// Shared types and constants for the ROM message UART streamer.
package rom_msg_uart_tx_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned COUNT_W    = 5;

    localparam logic [DATA_BITS-1:0] ASCII_NUL = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START_BIT,
        ST_DATA_BITS,
        ST_STOP_BIT,
        ST_DONE
    } state_e;

    // Width able to hold 0..clks-1; never below one bit.
    function automatic int unsigned baud_cnt_w(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/rom_msg_uart_tx_if.sv
// Control, ROM and serial signals of the message streamer.
interface rom_msg_uart_tx_if;

    logic                                        start;
    logic [rom_msg_uart_tx_pkg::ADDR_W-1:0]      rom_addr;
    logic [rom_msg_uart_tx_pkg::DATA_BITS-1:0]   rom_data;
    logic                                        tx;
    logic                                        busy;
    logic                                        done;
    logic [rom_msg_uart_tx_pkg::COUNT_W-1:0]     char_count;

    modport master (
        input  start,
        input  rom_data,
        output rom_addr,
        output tx,
        output busy,
        output done,
        output char_count
    );

    modport slave (
        output start,
        output rom_data,
        input  rom_addr,
        input  tx,
        input  busy,
        input  done,
        input  char_count
    );

endinterface

// File: rtl/rom_msg_uart_tx_baud_gen.sv
// Bit-period counter; bit_tick marks the last cycle of each UART bit.
module rom_msg_uart_tx_baud_gen
    import rom_msg_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CNT_W = baud_cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if (clear || (cnt == LAST_CNT)) begin
            cnt_next = '0;
        end
    end

    // Tick is registered alongside the count so it is high exactly when cnt==LAST_CNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_tick <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            bit_tick <= (cnt_next == LAST_CNT);
        end
    end

endmodule

// File: rtl/rom_msg_uart_tx.sv
// Walks the character ROM from address 0 and sends each byte as an 8N1 frame
// until a NUL byte or the last address.
module rom_msg_uart_tx
    import rom_msg_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rom_msg_uart_tx_if.master  bus
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = '1;

    state_e                 state;
    state_e                 state_next;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   shreg_next;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt_next;
    logic [ADDR_W-1:0]      rom_addr;
    logic [ADDR_W-1:0]      rom_addr_next;
    logic [COUNT_W-1:0]     char_count;
    logic [COUNT_W-1:0]     char_count_next;
    logic                   tx;
    logic                   tx_next;
    logic                   busy;
    logic                   busy_next;
    logic                   done;
    logic                   done_next;
    logic                   baud_clear;
    logic                   bit_tick;

    rom_msg_uart_tx_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            rom_addr   <= '0;
            char_count <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            bit_cnt    <= bit_cnt_next;
            rom_addr   <= rom_addr_next;
            char_count <= char_count_next;
            tx         <= tx_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    // Next state; tx is derived from the current state so the line lags the FSM by one cycle.
    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        bit_cnt_next    = bit_cnt;
        rom_addr_next   = rom_addr;
        char_count_next = char_count;
        tx_next         = 1'b1;
        baud_clear      = 1'b1;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next      = ST_FETCH;
                    rom_addr_next   = '0;
                    char_count_next = '0;
                end
            end
            ST_FETCH: begin
                shreg_next   = bus.rom_data;
                bit_cnt_next = '0;
                state_next   = (bus.rom_data == ASCII_NUL) ? ST_DONE : ST_START_BIT;
            end
            ST_START_BIT: begin
                baud_clear = 1'b0;
                tx_next    = 1'b0;
                if (bit_tick) begin
                    state_next = ST_DATA_BITS;
                end
            end
            ST_DATA_BITS: begin
                baud_clear = 1'b0;
                tx_next    = shreg[0];
                if (bit_tick) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = ST_STOP_BIT;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            ST_STOP_BIT: begin
                baud_clear = 1'b0;
                if (bit_tick) begin
                    char_count_next = char_count + COUNT_W'(1);
                    if (rom_addr == LAST_ADDR) begin
                        state_next = ST_DONE;
                    end else begin
                        rom_addr_next = rom_addr + ADDR_W'(1);
                        state_next    = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_FETCH)     || (state_next == ST_START_BIT) ||
                    (state_next == ST_DATA_BITS) || (state_next == ST_STOP_BIT);
        done_next = (state_next == ST_DONE);
    end

    assign bus.rom_addr   = rom_addr;
    assign bus.char_count = char_count;
    assign bus.tx         = tx;
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule

// File: tb/tb_rom_msg_uart_tx.sv
// Directed bench: ROM model, per-cycle tx trace, offline UART decode.
module tb_rom_msg_uart_tx;
    import rom_msg_uart_tx_pkg::*;

    localparam int unsigned CPB = 4;

    logic clk;
    logic rst_n;
    int   rom_mode;

    int   total;
    int   bad;

    logic       trace[$];
    logic       nom_trace[$];
    logic [7:0] rx[$];
    int         done_at;
    int         done_cnt;
    logic       busy_c1;
    logic       busy_at_done;
    int         stop_err;

    rom_msg_uart_tx_if bus();

    rom_msg_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: "STUDENT" then NUL; mode 1: all NUL; mode 2: all 0xFF.
    function automatic logic [7:0] rom_read(input int mode, input logic [3:0] a);
        if (mode == 1) return 8'h00;
        if (mode == 2) return 8'hFF;
        case (a)
            4'd0:    return 8'h53;
            4'd1:    return 8'h54;
            4'd2:    return 8'h55;
            4'd3:    return 8'h44;
            4'd4:    return 8'h45;
            4'd5:    return 8'h4E;
            4'd6:    return 8'h54;
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.rom_data = rom_read(rom_mode, bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start (optionally poking it again while busy and in DONE), trace tx for budget cycles.
    task automatic run_msg(input int budget, input bit poke);
        trace.delete();
        trace.push_back(1'b1);
        done_at      = 0;
        done_cnt     = 0;
        busy_c1      = 1'b0;
        busy_at_done = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            trace.push_back(bus.tx);
            if (k == 1) busy_c1 = bus.busy;
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at      = k;
                    busy_at_done = bus.busy;
                end
            end
            bus.start = poke && ((k < 289) ? ((k % 13) == 5) : (k == 289));
        end
        bus.start = 1'b0;
    endtask

    // Find start bits in the trace and sample every bit in its middle.
    task automatic decode();
        int i;
        rx.delete();
        stop_err = 0;
        i = 1;
        while (i < trace.size()) begin
            if (trace[i] == 1'b0 && trace[i-1] == 1'b1) begin
                logic [7:0] b;
                int idx;
                b = '0;
                for (int j = 0; j < 8; j++) begin
                    idx = i + CPB * (1 + j) + CPB / 2;
                    if (idx < trace.size()) b[j] = trace[idx];
                end
                idx = i + CPB * 9 + CPB / 2;
                if (idx >= trace.size() || trace[idx] != 1'b1) stop_err++;
                rx.push_back(b);
                i += FRAME_BITS * CPB;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_student(input string tag);
        logic [7:0] exp_msg [7];
        exp_msg = '{8'h53, 8'h54, 8'h55, 8'h44, 8'h45, 8'h4E, 8'h54};
        decode();
        check({tag, "_nchars"}, rx.size(), 7);
        check({tag, "_stop"}, stop_err, 0);
        for (int n = 0; n < 7; n++) begin
            check($sformatf("%s_char%0d", tag, n), (n < rx.size()) ? 32'(rx[n]) : 32'hDEAD,
                  32'(exp_msg[n]));
        end
    endtask

    initial begin
        int zeros;
        int non_ff;
        int diffs;
        total     = 0;
        bad       = 0;
        rom_mode  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", bus.rom_addr, 0);
        check("rst_count", bus.char_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal "STUDENT"
        run_msg(295, 1'b0);
        check("nom_tx_c2_high", trace[2], 1);
        check("nom_tx_c3_low", trace[3], 0);
        check("nom_busy_c1", busy_c1, 1);
        check("nom_done_at", done_at, 289);
        check("nom_done_cnt", done_cnt, 1);
        check("nom_busy_at_done", busy_at_done, 0);
        check_student("nom");
        check("nom_count", bus.char_count, 7);
        check("nom_addr", bus.rom_addr, 7);
        nom_trace = trace;

        // Empty message
        rom_mode = 1;
        run_msg(10, 1'b0);
        zeros = 0;
        for (int k = 1; k < trace.size(); k++) if (trace[k] == 1'b0) zeros++;
        check("empty_tx_low_cycles", zeros, 0);
        check("empty_done_at", done_at, 2);
        check("empty_done_cnt", done_cnt, 1);
        check("empty_count", bus.char_count, 0);
        check("empty_addr", bus.rom_addr, 0);

        // Full ROM of 0xFF
        rom_mode = 2;
        run_msg(662, 1'b0);
        decode();
        non_ff = 0;
        foreach (rx[n]) if (rx[n] != 8'hFF) non_ff++;
        check("full_nchars", rx.size(), 16);
        check("full_non_ff", non_ff, 0);
        check("full_stop", stop_err, 0);
        check("full_done_at", done_at, 657);
        check("full_done_cnt", done_cnt, 1);
        check("full_count", bus.char_count, 16);
        check("full_addr", bus.rom_addr, 15);

        // Start pokes while busy and in DONE must not disturb anything
        rom_mode = 0;
        run_msg(295, 1'b1);
        diffs = 0;
        if (trace.size() != nom_trace.size()) diffs = 9999;
        else foreach (trace[k]) if (trace[k] !== nom_trace[k]) diffs++;
        check("poke_trace_diffs", diffs, 0);
        check("poke_done_at", done_at, 289);
        check("poke_done_cnt", done_cnt, 1);
        check("poke_count", bus.char_count, 7);

        // Reset during a data bit of the third character
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (94) @(negedge clk);
        check("mid_busy_before", bus.busy, 1);
        check("mid_addr_before", bus.rom_addr, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", bus.tx, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_addr", bus.rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_msg(295, 1'b0);
        check_student("after_rst");
        check("after_rst_done_at", done_at, 289);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_msg_uart_tx.md
# rom_msg_uart_tx

Message streamer that sits directly downstream of the 16-entry character ROM. On a start request it walks the ROM address space from 0 and serializes each returned byte as an 8N1 UART frame. Streaming ends at the first NUL (0x00) byte or after address 15. The ROM is a separate combinational instance; this block drives its address and consumes its data.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request to stream one message; sampled only in IDLE.
- rom_addr  output  4  address to the ROM; registered.
- rom_data  input  8  ROM read data; combinational from rom_addr.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a message is in progress.
- done  output  1  one-cycle pulse when a message ends.
- char_count  output  5  characters fully sent in the current or last message, 0..16.

## Operation
- States: IDLE, FETCH, START_BIT, DATA_BITS, STOP_BIT, DONE.
- Reset (asynchronous, immediate):
  - tx=1, busy=0, done=0, rom_addr=0, char_count=0.
  - State IDLE; bit and baud counters 0.
- IDLE: on start=1, go to FETCH. rom_addr=0 and char_count=0 are set on that same edge.
- FETCH (exactly 1 cycle): register rom_data into the shift register.
  - rom_data==0x00: go to DONE; no frame is sent.
  - Otherwise: go to START_BIT.
- START_BIT: tx=0 for CLKS_PER_BIT cycles, then go to DATA_BITS.
- DATA_BITS: 8 bits, LSB first, CLKS_PER_BIT cycles each, then go to STOP_BIT.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. On the final cycle, char_count increments.
  - rom_addr==15: go to DONE. rom_addr does not wrap.
  - Otherwise: rom_addr increments and the block goes to FETCH.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
- busy=1 in FETCH, START_BIT, DATA_BITS and STOP_BIT; 0 in IDLE and DONE.
- tx=1 in IDLE, FETCH and DONE.
- start is ignored in all states except IDLE, including DONE.
  - If start is held high, a new message begins on the edge after DONE, i.e. the first IDLE cycle.
- char_count and rom_addr hold their final values after DONE until the next start.

## Timing
- Edge E samples start=1 in IDLE. FETCH occupies the cycle after E, and busy=1 from E.
- tx falls at edge E+2.
- Per character: 1 FETCH cycle + 10×CLKS_PER_BIT frame cycles.
- Message of N characters ended by NUL: done is high in cycle N×(1+10×CLKS_PER_BIT)+2 after E.
- Message of 16 characters: done is high in cycle 16×(1+10×CLKS_PER_BIT)+1 after E.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rst_n low mid-frame: tx goes high immediately, truncating the frame. No completion pulse is generated.

## Structure
- Shared package contents:
  - State enum.
  - FRAME_BITS=10, DATA_BITS=8.
  - ASCII_NUL=8'h00.
  - Function computing the baud counter width from CLKS_PER_BIT.
- Sub-module baud_gen:
  - Counter 0..CLKS_PER_BIT-1 with clear input and one-cycle bit_tick output.
  - Same clk/rst_n as the parent.
- Top-level wiring (instantiates both this block and the ROM) lives outside this block.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: assert rst_n=0 → tx=1, busy=0, done=0, rom_addr=0, char_count=0.
- Nominal: with the real ROM, one start pulse →
  - UART monitor decodes 0x53 0x54 0x55 0x44 0x45 0x4E 0x54 ("STUDENT").
  - done pulses once, 289 cycles after the start edge.
  - char_count=7, rom_addr=7.
- Empty message: ROM stub returns 0x00 at address 0, start pulse →
  - tx never goes low.
  - done pulses in cycle 2; char_count=0.
- Full ROM: stub returns 0xFF at every address, start pulse →
  - 16 frames are sent.
  - done in cycle 657; char_count=16, rom_addr=15, no wrap.
- Start while busy: extra start pulses during frames and in the DONE cycle → bit-identical tx waveform and done timing versus the nominal case.
- Reset mid-operation: rst_n low during a data bit of character 3 (0x55) →
  - tx=1 and busy=0 immediately.
  - A following start streams "STUDENT" from address 0.
